// File: rtl/cam_pkg.sv
// Shared types and default widths for the cam controller slice.
package cam_pkg;

   localparam int unsigned ARRAY_WIDTH_LOG2_DEF = 5;
   localparam int unsigned ARRAY_SIZE_LOG2_DEF  = 5;
   localparam int unsigned STAT_W               = 16;

   typedef enum logic [1:0] {
      OP_READ   = 2'd0,
      OP_WRITE  = 2'd1,
      OP_SEARCH = 2'd2,
      OP_INSERT = 2'd3
   } cam_op_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT      = 3'd2,
      INS_WRITE = 3'd3,
      RESP      = 3'd4
   } cam_ctrl_state_t;

   // Saturating increment for the optional statistics counters.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/cam_alloc_ptr.sv
// Round-robin allocation slot pointer; wraps naturally at 2**PTR_W.
module cam_alloc_ptr
   import cam_pkg::*;
#(
   parameter int unsigned PTR_W = ARRAY_SIZE_LOG2_DEF
) (
   input  logic             clk,
   input  logic             reset_i,
   input  logic             advance_i,
   output logic [PTR_W-1:0] ptr_o
);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/cam_ctrl.sv
// Initiator-side cam controller: one command at a time, READ/WRITE/SEARCH/INSERT.
// Optional hit/miss statistics outputs are enabled with CAM_CTRL_STATS_EN.
module cam_ctrl
   import cam_pkg::*;
#(
   parameter int unsigned ARRAY_WIDTH_LOG2 = ARRAY_WIDTH_LOG2_DEF,
   parameter int unsigned ARRAY_SIZE_LOG2  = ARRAY_SIZE_LOG2_DEF
) (
   input  logic                          clk,
   input  logic                          reset_i,
`ifdef CAM_CTRL_STATS_EN
   output logic [STAT_W-1:0]             stat_hits_o,
   output logic [STAT_W-1:0]             stat_misses_o,
`endif
   input  logic                          cmd_valid_i,
   output logic                          cmd_ready_o,
   input  logic [1:0]                    cmd_op_i,
   input  logic [ARRAY_SIZE_LOG2-1:0]    cmd_index_i,
   input  logic [(1<<ARRAY_WIDTH_LOG2)-1:0] cmd_data_i,
   output logic                          rsp_valid_o,
   input  logic                          rsp_ready_i,
   output logic                          rsp_hit_o,
   output logic [ARRAY_SIZE_LOG2-1:0]    rsp_index_o,
   output logic [(1<<ARRAY_WIDTH_LOG2)-1:0] rsp_data_o,
   output logic                          cam_read_o,
   output logic [ARRAY_SIZE_LOG2-1:0]    cam_read_index_o,
   output logic                          cam_write_o,
   output logic [ARRAY_SIZE_LOG2-1:0]    cam_write_index_o,
   output logic [(1<<ARRAY_WIDTH_LOG2)-1:0] cam_write_data_o,
   output logic                          cam_search_o,
   output logic [(1<<ARRAY_WIDTH_LOG2)-1:0] cam_search_data_o,
   input  logic                          cam_read_valid_i,
   input  logic [(1<<ARRAY_WIDTH_LOG2)-1:0] cam_read_value_i,
   input  logic                          cam_search_valid_i,
   input  logic [ARRAY_SIZE_LOG2-1:0]    cam_search_index_i
);

   localparam int unsigned DW = 1 << ARRAY_WIDTH_LOG2;
   localparam int unsigned IW = ARRAY_SIZE_LOG2;

   cam_ctrl_state_t state_q, state_d;

   // Latched command
   cam_op_t         op_q, op_d;
   logic [IW-1:0]   index_q, index_d;
   logic [DW-1:0]   data_q, data_d;

   // Registered outputs
   logic            cmd_ready_q, cmd_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_hit_q, rsp_hit_d;
   logic [IW-1:0]   rsp_index_q, rsp_index_d;
   logic [DW-1:0]   rsp_data_q, rsp_data_d;
   logic            cam_read_q, cam_read_d;
   logic [IW-1:0]   cam_read_index_q, cam_read_index_d;
   logic            cam_write_q, cam_write_d;
   logic [IW-1:0]   cam_write_index_q, cam_write_index_d;
   logic [DW-1:0]   cam_write_data_q, cam_write_data_d;
   logic            cam_search_q, cam_search_d;
   logic [DW-1:0]   cam_search_data_q, cam_search_data_d;

   logic            alloc_adv_c;
   logic [IW-1:0]   alloc_ptr;

   cam_alloc_ptr #(
      .PTR_W (IW)
   ) u_alloc_ptr (
      .clk       (clk),
      .reset_i   (reset_i),
      .advance_i (alloc_adv_c),
      .ptr_o     (alloc_ptr)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and command latch
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      index_d = index_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               state_d = ISSUE;
               op_d    = cam_op_t'(cmd_op_i);
               index_d = cmd_index_i;
               data_d  = cmd_data_i;
            end
         end
         ISSUE:     state_d = (op_q == OP_WRITE) ? RESP : WAIT;
         WAIT:      state_d = (op_q == OP_INSERT && !cam_search_valid_i) ? INS_WRITE : RESP;
         INS_WRITE: state_d = RESP;
         RESP: begin
            if (rsp_ready_i) begin
               state_d = IDLE;
            end
         end
         default:   state_d = IDLE;
      endcase
   end

   // Output decode; strobes are set on the edge entering the state that owns them
   always_comb begin
      cmd_ready_d       = (state_d == IDLE);
      rsp_valid_d       = rsp_valid_q;
      rsp_hit_d         = rsp_hit_q;
      rsp_index_d       = rsp_index_q;
      rsp_data_d        = rsp_data_q;
      cam_read_d        = 1'b0;
      cam_read_index_d  = cam_read_index_q;
      cam_write_d       = 1'b0;
      cam_write_index_d = cam_write_index_q;
      cam_write_data_d  = cam_write_data_q;
      cam_search_d      = 1'b0;
      cam_search_data_d = cam_search_data_q;
      alloc_adv_c       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid_i) begin
               unique case (op_d)
                  OP_READ: begin
                     cam_read_d       = 1'b1;
                     cam_read_index_d = cmd_index_i;
                  end
                  OP_WRITE: begin
                     cam_write_d       = 1'b1;
                     cam_write_index_d = cmd_index_i;
                     cam_write_data_d  = cmd_data_i;
                  end
                  default: begin
                     cam_search_d      = 1'b1;
                     cam_search_data_d = cmd_data_i;
                  end
               endcase
            end
         end
         ISSUE: begin
            if (op_q == OP_WRITE) begin
               rsp_valid_d = 1'b1;
               rsp_hit_d   = 1'b1;
               rsp_index_d = index_q;
               rsp_data_d  = data_q;
            end
         end
         WAIT: begin
            if (op_q == OP_READ) begin
               rsp_valid_d = 1'b1;
               rsp_hit_d   = cam_read_valid_i;
               rsp_index_d = index_q;
               rsp_data_d  = cam_read_value_i;
            end else if (op_q == OP_INSERT && !cam_search_valid_i) begin
               cam_write_d       = 1'b1;
               cam_write_index_d = alloc_ptr;
               cam_write_data_d  = data_q;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_hit_d   = cam_search_valid_i;
               rsp_index_d = cam_search_index_i;
               rsp_data_d  = data_q;
            end
         end
         INS_WRITE: begin
            rsp_valid_d = 1'b1;
            rsp_hit_d   = 1'b0;
            rsp_index_d = alloc_ptr;
            rsp_data_d  = data_q;
            alloc_adv_c = 1'b1;
         end
         RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset_i) begin
         op_q              <= OP_READ;
         index_q           <= '0;
         data_q            <= '0;
         cmd_ready_q       <= 1'b1;
         rsp_valid_q       <= 1'b0;
         rsp_hit_q         <= 1'b0;
         rsp_index_q       <= '0;
         rsp_data_q        <= '0;
         cam_read_q        <= 1'b0;
         cam_read_index_q  <= '0;
         cam_write_q       <= 1'b0;
         cam_write_index_q <= '0;
         cam_write_data_q  <= '0;
         cam_search_q      <= 1'b0;
         cam_search_data_q <= '0;
      end else begin
         op_q              <= op_d;
         index_q           <= index_d;
         data_q            <= data_d;
         cmd_ready_q       <= cmd_ready_d;
         rsp_valid_q       <= rsp_valid_d;
         rsp_hit_q         <= rsp_hit_d;
         rsp_index_q       <= rsp_index_d;
         rsp_data_q        <= rsp_data_d;
         cam_read_q        <= cam_read_d;
         cam_read_index_q  <= cam_read_index_d;
         cam_write_q       <= cam_write_d;
         cam_write_index_q <= cam_write_index_d;
         cam_write_data_q  <= cam_write_data_d;
         cam_search_q      <= cam_search_d;
         cam_search_data_q <= cam_search_data_d;
      end
   end

`ifdef CAM_CTRL_STATS_EN
   // Hit/miss counters sampled on the search response
   logic [STAT_W-1:0] hits_q, hits_d;
   logic [STAT_W-1:0] misses_q, misses_d;
   logic              stat_sample_c;

   always_comb begin
      stat_sample_c = (state_q == WAIT) && (op_q == OP_SEARCH || op_q == OP_INSERT);
      hits_d        = hits_q;
      misses_d      = misses_q;
      if (stat_sample_c) begin
         if (cam_search_valid_i) begin
            hits_d = sat_inc(hits_q);
         end else begin
            misses_d = sat_inc(misses_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset_i) begin
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         hits_q   <= hits_d;
         misses_q <= misses_d;
      end
   end

   assign stat_hits_o   = hits_q;
   assign stat_misses_o = misses_q;
`endif

   assign cmd_ready_o       = cmd_ready_q;
   assign rsp_valid_o       = rsp_valid_q;
   assign rsp_hit_o         = rsp_hit_q;
   assign rsp_index_o       = rsp_index_q;
   assign rsp_data_o        = rsp_data_q;
   assign cam_read_o        = cam_read_q;
   assign cam_read_index_o  = cam_read_index_q;
   assign cam_write_o       = cam_write_q;
   assign cam_write_index_o = cam_write_index_q;
   assign cam_write_data_o  = cam_write_data_q;
   assign cam_search_o      = cam_search_q;
   assign cam_search_data_o = cam_search_data_q;

endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a behavioural cam attached to its request ports.
module tb_cam_ctrl;
   import cam_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 5;
   localparam int unsigned NE = 32;

   logic          clk;
   logic          reset_i;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [1:0]    cmd_op_i;
   logic [IW-1:0] cmd_index_i;
   logic [DW-1:0] cmd_data_i;
   logic          rsp_valid_o;
   logic          rsp_ready_i;
   logic          rsp_hit_o;
   logic [IW-1:0] rsp_index_o;
   logic [DW-1:0] rsp_data_o;
   logic          cam_read_o;
   logic [IW-1:0] cam_read_index_o;
   logic          cam_write_o;
   logic [IW-1:0] cam_write_index_o;
   logic [DW-1:0] cam_write_data_o;
   logic          cam_search_o;
   logic [DW-1:0] cam_search_data_o;
   logic          cam_read_valid_i;
   logic [DW-1:0] cam_read_value_i;
   logic          cam_search_valid_i;
   logic [IW-1:0] cam_search_index_i;
`ifdef CAM_CTRL_STATS_EN
   logic [15:0]   stat_hits_o;
   logic [15:0]   stat_misses_o;
`endif

   int errors = 0;
   int checks = 0;

   cam_ctrl #(.ARRAY_WIDTH_LOG2(5), .ARRAY_SIZE_LOG2(5)) dut (
      .clk                (clk),
      .reset_i            (reset_i),
`ifdef CAM_CTRL_STATS_EN
      .stat_hits_o        (stat_hits_o),
      .stat_misses_o      (stat_misses_o),
`endif
      .cmd_valid_i        (cmd_valid_i),
      .cmd_ready_o        (cmd_ready_o),
      .cmd_op_i           (cmd_op_i),
      .cmd_index_i        (cmd_index_i),
      .cmd_data_i         (cmd_data_i),
      .rsp_valid_o        (rsp_valid_o),
      .rsp_ready_i        (rsp_ready_i),
      .rsp_hit_o          (rsp_hit_o),
      .rsp_index_o        (rsp_index_o),
      .rsp_data_o         (rsp_data_o),
      .cam_read_o         (cam_read_o),
      .cam_read_index_o   (cam_read_index_o),
      .cam_write_o        (cam_write_o),
      .cam_write_index_o  (cam_write_index_o),
      .cam_write_data_o   (cam_write_data_o),
      .cam_search_o       (cam_search_o),
      .cam_search_data_o  (cam_search_data_o),
      .cam_read_valid_i   (cam_read_valid_i),
      .cam_read_value_i   (cam_read_value_i),
      .cam_search_valid_i (cam_search_valid_i),
      .cam_search_index_i (cam_search_index_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural cam: responses registered on the edge that captures the strobe
   logic [DW-1:0] mem [NE];
   logic          vld [NE];
   logic          model_clr;

   always @(posedge clk) begin
      logic          found;
      logic [IW-1:0] fidx;
      cam_read_valid_i   <= 1'b0;
      cam_search_valid_i <= 1'b0;
      if (model_clr) begin
         for (int i = 0; i < NE; i++) begin
            vld[i] <= 1'b0;
            mem[i] <= '0;
         end
         cam_read_value_i   <= '0;
         cam_search_index_i <= '0;
      end else begin
         if (cam_write_o) begin
            mem[cam_write_index_o] <= cam_write_data_o;
            vld[cam_write_index_o] <= 1'b1;
         end
         if (cam_read_o) begin
            cam_read_valid_i <= vld[cam_read_index_o];
            cam_read_value_i <= mem[cam_read_index_o];
         end
         if (cam_search_o) begin
            found = 1'b0;
            fidx  = '0;
            for (int i = NE - 1; i >= 0; i--) begin
               if (vld[i] && mem[i] == cam_search_data_o) begin
                  found = 1'b1;
                  fidx  = IW'(i);
               end
            end
            cam_search_valid_i <= found;
            cam_search_index_i <= fidx;
         end
      end
   end

   typedef struct {
      cam_op_t       op;
      logic [IW-1:0] idx;
      logic [DW-1:0] data;
      logic          exp_hit;
      logic [IW-1:0] exp_idx;
      logic [DW-1:0] exp_data;
      logic          chk_idx;
      logic          chk_data;
      int            exp_lat;
      int            exp_wr;
   } vec_t;

   function automatic vec_t mk(input cam_op_t op, input logic [IW-1:0] idx, input logic [DW-1:0] data,
                               input logic exp_hit, input logic [IW-1:0] exp_idx,
                               input logic [DW-1:0] exp_data, input logic chk_idx,
                               input logic chk_data, input int exp_lat, input int exp_wr);
      vec_t v;
      v.op = op; v.idx = idx; v.data = data; v.exp_hit = exp_hit; v.exp_idx = exp_idx;
      v.exp_data = exp_data; v.chk_idx = chk_idx; v.chk_data = chk_data;
      v.exp_lat = exp_lat; v.exp_wr = exp_wr;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One command through handshake to response; hold = cycles of response back-pressure
   task automatic do_cmd(input vec_t v, input int hold, input string name);
      int            lat;
      int            nwr;
      logic          got;
      logic [IW-1:0] widx;
      logic [DW-1:0] wdat;
      @(negedge clk);
      check({name, "/cmd_ready"}, 64'(cmd_ready_o), 64'd1);
      cmd_valid_i = 1'b1;
      cmd_op_i    = v.op;
      cmd_index_i = v.idx;
      cmd_data_i  = v.data;
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b0;
      lat  = 1;
      nwr  = 0;
      got  = 1'b0;
      widx = '0;
      wdat = '0;
      while (lat <= 12) begin
         if (cam_write_o) begin
            nwr++;
            widx = cam_write_index_o;
            wdat = cam_write_data_o;
         end
         if (rsp_valid_o) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      check({name, "/rsp_arrived"}, 64'(got), 64'd1);
      if (!got) return;
      check({name, "/latency"}, 64'(lat), 64'(v.exp_lat));
      check({name, "/write_pulses"}, 64'(nwr), 64'(v.exp_wr));
      if (v.exp_wr == 1 && nwr == 1) begin
         check({name, "/write_index"}, 64'(widx), 64'(v.exp_idx));
         check({name, "/write_data"}, 64'(wdat), 64'(v.data));
      end
      check({name, "/hit"}, 64'(rsp_hit_o), 64'(v.exp_hit));
      if (v.chk_idx)  check({name, "/index"}, 64'(rsp_index_o), 64'(v.exp_idx));
      if (v.chk_data) check({name, "/data"}, 64'(rsp_data_o), 64'(v.exp_data));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         check({name, "/hold_valid"}, 64'(rsp_valid_o), 64'd1);
         check({name, "/hold_cmd_ready"}, 64'(cmd_ready_o), 64'd0);
         check({name, "/hold_hit"}, 64'(rsp_hit_o), 64'(v.exp_hit));
         check({name, "/hold_index"}, 64'(rsp_index_o), 64'(v.exp_idx));
         check({name, "/hold_data"}, 64'(rsp_data_o), 64'(v.exp_data));
      end
      rsp_ready_i = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready_i = 1'b0;
      check({name, "/post_valid"}, 64'(rsp_valid_o), 64'd0);
      check({name, "/post_cmd_ready"}, 64'(cmd_ready_o), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset_i = 1'b0;
   endtask

   vec_t tbl [10];

   initial begin
      tbl[0] = mk(OP_WRITE,  5'd3, 32'h3,  1'b1, 5'd3, 32'h3,  1'b1, 1'b1, 2, 1);
      tbl[1] = mk(OP_READ,   5'd3, 32'h0,  1'b1, 5'd3, 32'h3,  1'b1, 1'b1, 3, 0);
      tbl[2] = mk(OP_READ,   5'd4, 32'h0,  1'b0, 5'd4, 32'h0,  1'b1, 1'b0, 3, 0);
      tbl[3] = mk(OP_WRITE,  5'd5, 32'h5,  1'b1, 5'd5, 32'h5,  1'b1, 1'b1, 2, 1);
      tbl[4] = mk(OP_SEARCH, 5'd0, 32'h5,  1'b1, 5'd5, 32'h5,  1'b1, 1'b1, 3, 0);
      tbl[5] = mk(OP_SEARCH, 5'd0, 32'h9,  1'b0, 5'd0, 32'h9,  1'b0, 1'b1, 3, 0);
      tbl[6] = mk(OP_INSERT, 5'd0, 32'h7,  1'b0, 5'd0, 32'h7,  1'b1, 1'b1, 4, 1);
      tbl[7] = mk(OP_INSERT, 5'd0, 32'h7,  1'b1, 5'd0, 32'h7,  1'b1, 1'b1, 3, 0);
      tbl[8] = mk(OP_INSERT, 5'd0, 32'h11, 1'b0, 5'd1, 32'h11, 1'b1, 1'b1, 4, 1);
      tbl[9] = mk(OP_READ,   5'd0, 32'h0,  1'b1, 5'd0, 32'h7,  1'b1, 1'b1, 3, 0);

      reset_i     = 1'b1;
      model_clr   = 1'b1;
      cmd_valid_i = 1'b0;
      cmd_op_i    = '0;
      cmd_index_i = '0;
      cmd_data_i  = '0;
      rsp_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_i   = 1'b0;
      model_clr = 1'b0;

      check("reset/cmd_ready", 64'(cmd_ready_o), 64'd1);
      check("reset/rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("reset/strobes", 64'({cam_read_o, cam_write_o, cam_search_o}), 64'd0);
      check("reset/idx_outs", 64'({cam_read_index_o, cam_write_index_o, rsp_index_o}), 64'd0);
      check("reset/data_outs", 64'(cam_write_data_o | cam_search_data_o | rsp_data_o), 64'd0);

      for (int i = 0; i < 10; i++) begin
         do_cmd(tbl[i], 0, $sformatf("vec%0d", i));
      end

      // Reset while the INSERT of an absent value sits in WAIT
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_op_i    = OP_INSERT;
      cmd_data_i  = 32'h22;
      @(posedge clk);
      #1;
      cmd_valid_i = 1'b0;
      @(posedge clk);
      #1;
      reset_i = 1'b1;
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      check("rst_wait/rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_wait/cmd_ready", 64'(cmd_ready_o), 64'd1);
      check("rst_wait/strobes", 64'({cam_read_o, cam_write_o, cam_search_o}), 64'd0);
      do_cmd(mk(OP_INSERT, 5'd0, 32'h33, 1'b0, 5'd0, 32'h33, 1'b1, 1'b1, 4, 1), 0, "rst_wait/ins");
      do_cmd(mk(OP_SEARCH, 5'd0, 32'h22, 1'b0, 5'd0, 32'h22, 1'b0, 1'b1, 3, 0), 0, "rst_wait/absent");

      // 33 misses from a fresh pointer: the last wraps to slot 0 under back-pressure
      do_reset();
      for (int k = 0; k < 33; k++) begin
         do_cmd(mk(OP_INSERT, 5'd0, 32'h1000 + 32'(k), 1'b0, IW'(k % 32), 32'h1000 + 32'(k),
                   1'b1, 1'b1, 4, 1), (k == 32) ? 5 : 0, $sformatf("wrap%0d", k));
      end
      do_cmd(mk(OP_READ, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1020, 1'b1, 1'b1, 3, 0), 0, "wrap/read0");
      do_cmd(mk(OP_READ, 5'd1, 32'h0, 1'b1, 5'd1, 32'h1001, 1'b1, 1'b1, 3, 0), 0, "wrap/read1");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

endmodule
